// File: rtl/tinyqv_counter_pkg.sv
// Shared definitions for the TinyQV counter writer: FSM state encoding and
// the helper that turns a word length in nibbles into the phase counter width.
package tinyqv_counter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SHIFT  = 3'd2,
    DONE   = 3'd3,
    VERIFY = 3'd4
  } wr_state_t;

  localparam int DEFAULT_NIBBLES = 8;

  // Width of the nibble phase counter; a 2-nibble word still needs one bit.
  function automatic int phase_width(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/tinyqv_nibble_shifter.sv
// Load/shift register holding the word being written, low nibble first.
// data_out shows the current low nibble only while drive is high.
module tinyqv_nibble_shifter #(
  parameter int NIBBLES = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   load,
  input  logic                   shift,
  input  logic                   drive,
  input  logic [4*NIBBLES-1:0]   load_data,
  output logic [3:0]             data_out
);

  logic [4*NIBBLES-1:0] sh;

  // Load a new word on acceptance; otherwise move the next nibble down.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh <= '0;
    end else if (load) begin
      sh <= load_data;
    end else if (shift) begin
      sh <= {4'b0000, sh[4*NIBBLES-1:4]};
    end
  end

  assign data_out = drive ? sh[3:0] : 4'b0000;

endmodule

// File: rtl/tinyqv_counter_writer.sv
// Writes a parallel word into TinyQV's nibble-serial counter through its
// set/data_in port, one nibble per cycle aligned to the core's nibble phase.
// Optional read-back check: define TINYQV_COUNTER_WRITER_VERIFY_EN to add the
// data_in/vfail ports and a VERIFY pass after the write.
//
// Handshake: a request is taken on a clk edge where wr_valid && wr_ready.
// wr_ready is high only in IDLE; wr_valid seen while busy is dropped, not queued.
module tinyqv_counter_writer
  import tinyqv_counter_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES,
  localparam int PW = phase_width(NIBBLES)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [PW-1:0]         counter,
  input  logic                  wr_valid,
  input  logic [4*NIBBLES-1:0]  wr_data,
  output logic                  wr_ready,
  output logic                  set,
  output logic [3:0]            data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
  input  logic [3:0]            data_in,
  output logic                  vfail,
`endif
  output logic [2:0]            fsm_state
);

  localparam logic [PW-1:0] LAST = PW'(NIBBLES - 1);

  wr_state_t     state;
  logic [PW-1:0] idx;
  logic          done_q;
  logic          err_q;
  logic          load;

  assign load      = (state == IDLE) && wr_valid;
  assign wr_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign set       = (state == SHIFT);
  assign done      = done_q;
  assign err       = err_q;
  assign fsm_state = state;

`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
  logic [4*NIBBLES-1:0] copy;
  logic                 mism;
  logic                 vfail_q;
  logic [3:0]           exp_nib;
  logic                 cur_bad;

  // Retained copy of the written word, used to check the read-back nibbles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      copy <= '0;
    end else if (load) begin
      copy <= wr_data;
    end
  end

  assign exp_nib = 4'(copy >> {counter, 2'b00});
  assign cur_bad = (data_in != exp_nib);
  assign vfail   = vfail_q;
`endif

  tinyqv_nibble_shifter #(
    .NIBBLES (NIBBLES)
  ) u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .shift     (state == SHIFT),
    .drive     (state == SHIFT),
    .load_data (wr_data),
    .data_out  (data_out)
  );

  // Write sequencer: wait for the phase wrap, stream NIBBLES nibbles in
  // lockstep with counter, then report done (or err on a phase slip).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      idx     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
      mism    <= 1'b0;
      vfail_q <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
      vfail_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (wr_valid) state <= WAIT;
        end
        WAIT: begin
          // Acceptance on a wrap edge lands here first, so the write waits
          // for the next full phase rotation.
          if (counter == LAST) begin
            state <= SHIFT;
            idx   <= '0;
          end
        end
        SHIFT: begin
          if (counter != idx) begin
            state <= IDLE;
            idx   <= '0;
            err_q <= 1'b1;
          end else if (idx == LAST) begin
            idx <= '0;
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
            state <= VERIFY;
            mism  <= 1'b0;
`else
            state  <= DONE;
            done_q <= 1'b1;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
        VERIFY: begin
          if (cur_bad) mism <= 1'b1;
          if (idx == LAST) begin
            state <= IDLE;
            idx   <= '0;
            if (mism || cur_bad) vfail_q <= 1'b1;
            else                 done_q  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinyqv_counter_writer.sv
// Directed bench for tinyqv_counter_writer (NIBBLES=8). A free-running phase
// counter is modelled here; written nibbles are queued at acceptance and
// popped whenever the DUT drives set.
module tb_tinyqv_counter_writer;
  import tinyqv_counter_pkg::*;

  localparam int N = 8;
  localparam int W = 4 * N;
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
  localparam int DONE_LAT = 2 * N;
`else
  localparam int DONE_LAT = N;
`endif

  // ---------------- clock / reset / signals ----------------
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [2:0]   counter = 3'd0;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_ready, set, busy, done, err;
  logic [3:0]   data_out;
  logic [2:0]   fsm_state;
  logic [W-1:0] rb_word = '0;
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
  logic [3:0]   data_in;
  logic         vfail;
  always_comb data_in = 4'(rb_word >> (4 * counter));
`endif

  always #5 clk = ~clk;

  tinyqv_counter_writer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .counter   (counter),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .set       (set),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
    .data_in   (data_in),
    .vfail     (vfail),
`endif
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc_no, first_set, set_cnt, done_cnt, done_at, err_cnt, err_at;
  int vfail_cnt, vfail_at;
  bit phase_chk = 1'b1;
  bit skip = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr_stats();
    cyc_no = 0; first_set = -1; set_cnt = 0; done_cnt = 0; done_at = -1;
    err_cnt = 0; err_at = -1; vfail_cnt = 0; vfail_at = -1;
  endtask

  // One clock: advance the phase counter, then sample and score outputs.
  task automatic cyc();
    logic [3:0] e;
    @(posedge clk);
    #1;
    counter = skip ? counter + 3'd3 : counter + 3'd1;
    cyc_no++;
    chk("ready_vs_busy", wr_ready, !busy);
    if (set) begin
      set_cnt++;
      if (first_set < 0) first_set = cyc_no;
      if (phase_chk) chk("set_phase", counter, set_cnt - 1);
      if (exp_q.size() == 0) chk("set_without_expected", set, 0);
      else begin
        e = exp_q.pop_front();
        chk("data_out", data_out, e);
      end
    end else begin
      chk("idle_data_out", data_out, 0);
    end
    if (done) begin done_cnt++; done_at = cyc_no; end
    if (err) begin err_cnt++; err_at = cyc_no; chk("err_set_low", set, 0); end
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
    if (vfail) begin vfail_cnt++; vfail_at = cyc_no; end
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int t = 0;
    while (counter != p && t < 16) begin cyc(); t++; end
    chk("phase_reached", counter, p);
  endtask

  // Present a request in the cycle where counter == p; queue n_exp nibbles.
  task automatic start_write(input logic [W-1:0] d, input logic [2:0] p, input int n_exp);
    wait_phase(p);
    chk("ready_before_write", wr_ready, 1);
    clr_stats();
    wr_valid = 1'b1;
    wr_data  = d;
    rb_word  = d;
    for (int k = 0; k < n_exp; k++) exp_q.push_back(d[4*k +: 4]);
    cyc();
    chk("busy_after_accept", busy, 1);
  endtask

  function automatic int exp_first(input int p);
    return (p == N - 1) ? N + 1 : N - p;
  endfunction

  task automatic end_checks(input int fs);
    chk("first_set", first_set, fs);
    chk("set_count", set_cnt, N);
    chk("done_count", done_cnt, 1);
    chk("done_at", done_at, fs + DONE_LAT);
    chk("err_count", err_cnt, 0);
    chk("sb_empty", exp_q.size(), 0);
    chk("ready_after", wr_ready, 1);
`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
    chk("vfail_count", vfail_cnt, 0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] d;
    int p;
    clr_stats();

    // Reset state
    rstn = 1'b0;
    run(3);
    chk("rst_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_set", set, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_state", fsm_state, IDLE);
    rstn = 1'b1;
    run(2);

    // Accept at counter=3: set 5 cycles later, nibbles F..8
    start_write(32'h89ABCDEF, 3'd3, N);
    wr_valid = 1'b0; wr_data = '0;
    run(30);
    end_checks(5);

    // Accept on the wrap phase: full WAIT rotation first
    start_write(32'h0F1E2D3C, 3'd7, N);
    wr_valid = 1'b0;
    run(30);
    end_checks(9);

    // wr_valid held through busy with a different word: ignored
    start_write(32'hCAFEF00D, 3'd0, N);
    wr_data = 32'h1;
    while (cyc_no < exp_first(0) + DONE_LAT - 1) begin
      chk("ready_low_held", wr_ready, 0);
      cyc();
    end
    wr_valid = 1'b0;
    run(10);
    end_checks(exp_first(0));

    // Random words at random phases
    for (int r = 0; r < 3; r++) begin
      d = W'($urandom);
      p = $urandom_range(0, N - 1);
      start_write(d, 3'(p), N);
      wr_valid = 1'b0;
      run(30);
      end_checks(exp_first(p));
    end

    // Counter skips from 2 to 5 at SHIFT index 3
    start_write(32'h76543210, 3'd7, 4);
    wr_valid = 1'b0;
    phase_chk = 1'b0;
    while (cyc_no < 11) cyc();
    skip = 1'b1;
    cyc();
    skip = 1'b0;
    run(20);
    phase_chk = 1'b1;
    chk("skip_first_set", first_set, 9);
    chk("skip_set_count", set_cnt, 4);
    chk("skip_err_count", err_cnt, 1);
    chk("skip_err_at", err_at, 13);
    chk("skip_done_count", done_cnt, 0);
    chk("skip_sb_empty", exp_q.size(), 0);

    // Reset at SHIFT index 4 aborts silently
    start_write(32'hA5A55A5A, 3'd7, 5);
    wr_valid = 1'b0;
    while (cyc_no < 13) cyc();
    rstn = 1'b0;
    cyc();
    chk("abort_set", set, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", wr_ready, 1);
    rstn = 1'b1;
    run(20);
    chk("abort_set_count", set_cnt, 5);
    chk("abort_done_count", done_cnt, 0);
    chk("abort_err_count", err_cnt, 0);
    chk("abort_sb_empty", exp_q.size(), 0);

`ifdef TINYQV_COUNTER_WRITER_VERIFY_EN
    // Read-back matches
    start_write(32'h12345678, 3'd2, N);
    wr_valid = 1'b0;
    run(30);
    end_checks(exp_first(2));

    // Read-back differs in nibble 0
    start_write(32'h12345678, 3'd2, N);
    rb_word = 32'h12345679;
    wr_valid = 1'b0;
    run(30);
    chk("vf_set_count", set_cnt, N);
    chk("vf_done_count", done_cnt, 0);
    chk("vf_vfail_count", vfail_cnt, 1);
    chk("vf_vfail_at", vfail_at, exp_first(2) + DONE_LAT);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tinyqv_counter_writer.md
TINYQV_COUNTER_WRITER -- requirements
Module: tinyqv_counter_writer

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, meaning the word length in nibbles (word width = 4*NIBBLES; legal values 2..8, power of two).
REQ-002 SHALL have ports clk input 1 (clock) and rstn input 1 (reset: synchronous, active-low).
REQ-003 SHALL have port counter input log2(NIBBLES): the core's free-running nibble phase, incrementing by 1 mod NIBBLES every cycle.
REQ-004 SHALL have ports wr_valid input 1 and wr_data input 4*NIBBLES: the parallel write request.
REQ-005 SHALL have port wr_ready output 1: request accepted on a clk edge with wr_valid && wr_ready.
REQ-006 SHALL have ports set output 1 and data_out output 4: drive the nibble-serial counter's set/data_in port.
REQ-007 SHALL have ports busy output 1, done output 1 (single-cycle pulse) and err output 1 (single-cycle pulse).

Function
REQ-008 SHALL implement states IDLE, WAIT, SHIFT, DONE.
REQ-009 wr_ready SHALL be 1 only in IDLE; wr_valid in other states SHALL be ignored with no request loss tracking.
REQ-010 On acceptance SHALL latch wr_data into a shift register and go IDLE->WAIT.
REQ-011 In WAIT, on an edge where counter == NIBBLES-1, SHALL go to SHIFT with internal index 0; otherwise stay.
REQ-012 In SHIFT, set SHALL be 1 and data_out SHALL equal shift register bits [3:0] (combinational from registers, no dependence on wr_* inputs).
REQ-013 Each SHIFT cycle SHALL shift the register right by 4 and increment index; nibble k of the word SHALL appear in the cycle where counter == k.
REQ-014 After the cycle with index NIBBLES-1, SHALL go to DONE; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-015 Write latency: first set cycle is the cycle after counter == NIBBLES-1 is seen in WAIT; total set cycles exactly NIBBLES.
REQ-016 In SHIFT, if counter != index, SHALL pulse err for one cycle, deassert set from the next cycle, and return to IDLE without done.
REQ-017 Outside SHIFT, set SHALL be 0 and data_out SHALL be 4'b0.
REQ-018 busy SHALL be 1 in WAIT, SHIFT and DONE; wr_ready == !busy.
REQ-019 Acceptance on the same edge as counter == NIBBLES-1 SHALL enter WAIT (not SHIFT); the write starts at the next phase wrap.

Reset
REQ-020 On a clk edge with rstn low SHALL enter IDLE; shift register, index cleared; set=0, data_out=0, done=0, err=0, busy=0, wr_ready=1 from that edge.
REQ-021 Reset during SHIFT SHALL abort the write; no done or err pulse SHALL be produced for the aborted request.

Configuration
REQ-022 Macro TINYQV_COUNTER_WRITER_VERIFY_EN SHALL, when defined, add input data_in (4 bits, counter's readback nibble) and output vfail (1-bit pulse).
REQ-023 With the macro, DONE SHALL be replaced by state VERIFY lasting NIBBLES cycles, comparing data_in at counter == k against nibble k of the written word (retained copy); done pulses on the cycle after VERIFY if all matched, else vfail pulses instead.
REQ-024 Without the macro, data_in/vfail SHALL not exist and REQ-014 timing applies unchanged.

Structure
REQ-025 State encoding enum and NIBBLES-derived phase-width constant SHALL live in shared package tinyqv_counter_pkg.
REQ-026 A sub-module tinyqv_nibble_shifter (load/shift register, data_out mux) is natural; FSM stays in the top.

Verification
REQ-027 NIBBLES=8, wr_data=32'h89ABCDEF accepted at counter=3 -> set high 5 cycles later at counter=0 for 8 cycles, data_out F,E,D,C,B,A,9,8, done one cycle after.
REQ-028 Acceptance at counter=7 -> WAIT for 8 cycles, first set cycle at next counter=0.
REQ-029 wr_valid held during busy with wr_data=32'h1 -> ignored; only original word driven; wr_ready low until IDLE.
REQ-030 Counter skips a value in SHIFT (index 3, counter=5) -> err one cycle, set=0 next cycle, no done.
REQ-031 rstn low at SHIFT index 4 -> set=0, busy=0 from that edge, no done/err.
REQ-032 With TINYQV_COUNTER_WRITER_VERIFY_EN, model counter readback 32'h12345678 after writing 32'h12345678 -> done; readback 32'h12345679 -> vfail, no done.
